face_box_tx: RTL

FACE_BOX_TX -- requirements
Module: face_box_tx

---
 rtl/face_box_tx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/face_box_tx.sv
// face_box_tx
//   Serialises one face bounding box into a 10-byte frame for a UART byte
//   transmitter: HEADER, x_min hi/lo, x_max hi/lo, y_min hi/lo, y_max hi/lo,
//   CHK (XOR of the eight coordinate bytes). A one-entry pending buffer
//   absorbs a box that arrives while a frame is in flight. A later box
//   overwrites the buffered one and bumps a saturating overflow counter.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   box_valid  : one-cycle strobe, coordinates valid
//   x_min, x_max, y_min, y_max : box coordinates, CW bits each
//   tx_start   : one-cycle request to the byte transmitter
//   tx_data    : byte to send, held from tx_start until its tx_done
//   tx_done    : one-cycle "byte finished" strobe from the transmitter
//   busy       : high while a frame is being sent
//   frame_done : one-cycle pulse after the last byte's tx_done
//   ovf_cnt    : number of buffered boxes lost to overwrite (saturates)
module face_box_tx #(
  parameter int unsigned CW     = 10,
  parameter logic [7:0]  HEADER = 8'hAA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          box_valid,
  input  logic [CW-1:0] x_min,
  input  logic [CW-1:0] x_max,
  input  logic [CW-1:0] y_min,
  input  logic [CW-1:0] y_max,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic          busy,
  output logic          frame_done,
  output logic [7:0]    ovf_cnt
);

  localparam int unsigned BW = 4 * CW;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    frame_q [10];
  logic [BW-1:0] pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic          load;
  logic [BW-1:0] box_in;
  logic [BW-1:0] src;
  logic [3:0][7:0] hi_b;
  logic [3:0][7:0] lo_b;
  logic [7:0]    chk_byte;

  assign box_in = {x_min, x_max, y_min, y_max};
  // A buffered box always wins over a box arriving in the same cycle.
  assign src    = pend_full_q ? pend_q : box_in;

  // Split each coordinate into zero-extended high byte and low byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_coord
    logic [15:0] coord_ext;
    assign coord_ext = 16'(src[BW-1-gi*CW -: CW]);
    assign hi_b[gi]  = coord_ext[15:8];
    assign lo_b[gi]  = coord_ext[7:0];
  end

  assign chk_byte = hi_b[0] ^ lo_b[0] ^ hi_b[1] ^ lo_b[1] ^
                    hi_b[2] ^ lo_b[2] ^ hi_b[3] ^ lo_b[3];

  // Frame registers are only written from IDLE, so they stay frozen while busy.
  assign load = (state_q == S_IDLE) && (pend_full_q || box_valid);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      ovf_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 10; i++) frame_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      ovf_q        <= ovf_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      if (load) begin
        frame_q[0] <= HEADER;
        for (int i = 0; i < 4; i++) begin
          frame_q[1+2*i] <= hi_b[i];
          frame_q[2+2*i] <= lo_b[i];
        end
        frame_q[9] <= chk_byte;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pend_full_q || box_valid) state_d = S_SEND;
      S_SEND:  state_d = S_WAIT;
      S_WAIT:  if (tx_done) state_d = (idx_q == 4'd9) ? S_DONE : S_SEND;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    idx_d        = idx_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    ovf_d        = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          idx_d  = '0;
          busy_d = 1'b1;
        end
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = frame_q[idx_q];
      end
      S_WAIT: begin
        if (tx_done) begin
          if (idx_q == 4'd9) frame_done_d = 1'b1;
          else               idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: busy_d = 1'b0;
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      // Buffered box moves into the frame; a same-cycle box refills the buffer.
      if (pend_full_q) begin
        pend_full_d = box_valid;
        if (box_valid) pend_d = box_in;
      end
    end else if (box_valid) begin
      pend_d      = box_in;
      pend_full_d = 1'b1;
      if (pend_full_q && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ovf_cnt    = ovf_q;

endmodule
